// File: rtl/nonce_sched_if.sv
// rtl/nonce_sched_if.sv - job, issue and result signals of the nonce scheduler
// The host side drives jobs and digests; the scheduler side issues blocks.
interface nonce_sched_if;
    logic         start;
    logic         abort;
    logic [255:0] midstate;
    logic [95:0]  tail;
    logic [31:0]  nonce_first;
    logic [31:0]  nonce_last;
    logic [255:0] target;
    logic         en;
    logic [511:0] M;
    logic [255:0] Hin;
    logic         hash_valid;
    logic [255:0] hash;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;

    modport master (
        output start, abort, midstate, tail, nonce_first, nonce_last, target,
        output hash_valid, hash,
        input  en, M, Hin, busy, done, found, found_nonce
    );

    modport slave (
        input  start, abort, midstate, tail, nonce_first, nonce_last, target,
        input  hash_valid, hash,
        output en, M, Hin, busy, done, found, found_nonce
    );
endinterface

// File: rtl/nonce_sched.sv
// rtl/nonce_sched.sv - paces nonce blocks into a hash pipeline and matches results
// Issued nonces wait in a tag FIFO until their in-order digest returns.
module nonce_sched #(
    parameter int DELAY      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    nonce_sched_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (DELAY > 2) ? $clog2(DELAY) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(DELAY - 2);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   nonce_q, nonce_d;
    logic [31:0]   last_q, last_d;
    logic [95:0]   tail_q, tail_d;
    logic [255:0]  target_q, target_d;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;
    logic          stall_q, stall_d;
    logic          abort_q, abort_d;
    logic          found_q, found_d;
    logic [31:0]   found_nonce_q, found_nonce_d;
    logic [511:0]  m_q, m_d;
    logic [255:0]  hin_q, hin_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   tag_q [FIFO_DEPTH];

    logic push, pop, hit, stop, busy;

    function automatic logic [511:0] build_m(input logic [95:0] t, input logic [31:0] n);
        return {t, n, 32'h8000_0000, 320'd0, 32'h0000_0280};
    endfunction

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        last_d        = last_q;
        tail_d        = tail_q;
        target_d      = target_q;
        gap_cnt_d     = gap_cnt_q;
        stall_d       = stall_q;
        abort_d       = abort_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        m_d           = m_q;
        hin_d         = hin_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        busy = (state_q == S_ISSUE) || (state_q == S_GAP) || (state_q == S_DRAIN);
        push = (state_q == S_ISSUE);
        pop  = bus.hash_valid && (count_q != '0);
        hit  = pop && !found_q && (bus.hash <= target_q);
        // A hit in the very cycle of a gap decision must already block the next issue.
        stop = found_q || hit || abort_q || bus.abort;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        if (busy && bus.abort) abort_d = 1'b1;
        if (hit) begin
            found_d       = 1'b1;
            found_nonce_d = tag_q[rd_ptr_q];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    nonce_d       = bus.nonce_first;
                    last_d        = bus.nonce_last;
                    tail_d        = bus.tail;
                    target_d      = bus.target;
                    hin_d         = bus.midstate;
                    m_d           = build_m(bus.tail, bus.nonce_first);
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                    abort_d       = 1'b0;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gap_cnt_d = '0;
                stall_d   = 1'b0;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (stall_q) begin
                    // Nonce already advanced; only waiting for a free tag slot.
                    if (stop) begin
                        state_d = S_DRAIN;
                    end else if (count_q != FULL) begin
                        m_d     = build_m(tail_q, nonce_q);
                        state_d = S_ISSUE;
                    end
                end else if (gap_cnt_q == GAP_LAST) begin
                    if (stop || (nonce_q >= last_q)) begin
                        state_d = S_DRAIN;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        if (count_q == FULL) begin
                            stall_d = 1'b1;
                        end else begin
                            m_d     = build_m(tail_q, nonce_q + 32'd1);
                            state_d = S_ISSUE;
                        end
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (count_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            nonce_q       <= '0;
            last_q        <= '0;
            tail_q        <= '0;
            target_q      <= '0;
            gap_cnt_q     <= '0;
            stall_q       <= 1'b0;
            abort_q       <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            m_q           <= '0;
            hin_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            last_q        <= last_d;
            tail_q        <= tail_d;
            target_q      <= target_d;
            gap_cnt_q     <= gap_cnt_d;
            stall_q       <= stall_d;
            abort_q       <= abort_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            m_q           <= m_d;
            hin_q         <= hin_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Tag storage needs no reset: occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (push) tag_q[wr_ptr_q] <= nonce_q;
    end

    assign bus.en          = (state_q == S_ISSUE);
    assign bus.busy        = busy;
    assign bus.done        = (state_q == S_DONE);
    assign bus.found       = found_q;
    assign bus.found_nonce = found_nonce_q;
    assign bus.M           = m_q;
    assign bus.Hin         = hin_q;
endmodule

// File: tb/tb_nonce_sched.sv
// tb/tb_nonce_sched.sv - randomized job bench for nonce_sched with a transaction-level model
module tb_nonce_sched;
    localparam int DELAY = 16;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    nonce_sched_if bus();

    nonce_sched #(.DELAY(DELAY), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] nonce;
    } pend_t;

    pend_t        pend_q[$];
    int unsigned  issue_cyc[$];
    logic [31:0]  issue_nonce[$];
    int unsigned  res_cyc[$];
    int unsigned  cyc;
    int unsigned  lat;
    int unsigned  budget;
    bit           done_seen;
    bit           prev_done;
    int unsigned  done_cyc;
    int           m_err;
    int           stable_err;
    logic [511:0] last_m;
    logic [95:0]  cur_tail;
    logic [255:0] cur_mid;
    logic [255:0] cur_target;
    logic [31:0]  hit_a;
    logic [31:0]  hit_b;
    int           total;
    int           bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [511:0] exp_m(input logic [95:0] t, input logic [31:0] n);
        return {t[95:64], t[63:32], t[31:0], n, 32'h8000_0000, 320'd0, 32'h0000_0280};
    endfunction

    function automatic logic [255:0] hash_for(input logic [31:0] n);
        if (n == hit_a) return cur_target;
        if (n == hit_b) return cur_target - 256'd7;
        return cur_target + 256'd1 + {224'd0, n ^ 32'h5a5a_1234};
    endfunction

    function automatic logic [255:0] rand_target();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        t[255] = 1'b0;
        t[254] = 1'b1;
        return t;
    endfunction

    // Observes issues, plays the hash pipeline (fixed latency, in order) and logs timing.
    initial begin
        cyc = 0;
        prev_done = 1'b0;
        last_m = '0;
        bus.hash_valid = 1'b0;
        bus.hash = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) last_m = '0;
            if (bus.en) begin
                issue_cyc.push_back(cyc);
                issue_nonce.push_back(bus.M[415:384]);
                if (bus.M !== exp_m(cur_tail, bus.M[415:384]) || bus.Hin !== cur_mid) m_err++;
                last_m = bus.M;
                pend_q.push_back('{due: cyc + lat, nonce: bus.M[415:384]});
            end else if (bus.M !== last_m) begin
                stable_err++;
            end
            if (bus.done && !prev_done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
            end
            prev_done = bus.done;
            bus.hash_valid = 1'b0;
            if (budget > 0 && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.hash_valid = 1'b1;
                bus.hash = hash_for(pend_q[0].nonce);
                void'(pend_q.pop_front());
                res_cyc.push_back(cyc);
                budget--;
            end
        end
    end

    task automatic launch(input logic [31:0] first, input logic [31:0] last, input logic [255:0] tgt);
        @(negedge clk);
        issue_cyc.delete();
        issue_nonce.delete();
        res_cyc.delete();
        done_seen = 1'b0;
        m_err = 0;
        stable_err = 0;
        for (int i = 0; i < 3; i++) cur_tail[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) cur_mid[i*32 +: 32] = $urandom;
        cur_target = tgt;
        bus.tail = cur_tail;
        bus.midstate = cur_mid;
        bus.target = tgt;
        bus.nonce_first = first;
        bus.nonce_last = last;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_seen) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_issues(input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (issue_cyc.size() >= n) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (bus.en !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", bus.en); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        total++; if (bus.found !== 1'b0) begin bad++; $display("FAIL reset_found: got %0b want 0", bus.found); end
        total++; if (bus.found_nonce !== 32'd0) begin bad++; $display("FAIL reset_found_nonce: got %0h want 0", bus.found_nonce); end
        total++; if (bus.M !== 512'd0) begin bad++; $display("FAIL reset_M: got nonzero want 0"); end
        total++; if (bus.Hin !== 256'd0) begin bad++; $display("FAIL reset_Hin: got nonzero want 0"); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        lat = 80;
        budget = '1;
        hit_a = 32'hFFFF_0000;
        hit_b = 32'hFFFF_0000;
        launch(32'd5, 32'd7, rand_target());
        repeat (20) @(negedge clk);
        bus.nonce_first = 32'd999;
        bus.tail = ~cur_tail;
        bus.midstate = ~cur_mid;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(400, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_done: got %0b want 1", ok); end
        total++; if (issue_cyc.size() != 3) begin bad++; $display("FAIL basic_issues: got %0d want 3", issue_cyc.size()); end
        if (issue_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (issue_nonce[i] !== 32'd5 + i) begin bad++; $display("FAIL basic_nonce%0d: got %0d want %0d", i, issue_nonce[i], 5 + i); end
            end
            total++; if (issue_cyc[1] - issue_cyc[0] != DELAY) begin bad++; $display("FAIL basic_gap1: got %0d want %0d", issue_cyc[1] - issue_cyc[0], DELAY); end
            total++; if (issue_cyc[2] - issue_cyc[0] != 2 * DELAY) begin bad++; $display("FAIL basic_gap2: got %0d want %0d", issue_cyc[2] - issue_cyc[0], 2 * DELAY); end
        end
        total++; if (res_cyc.size() != 3) begin bad++; $display("FAIL basic_results: got %0d want 3", res_cyc.size()); end
        if (res_cyc.size() == 3) begin
            total++;
            if (done_cyc <= res_cyc[2] || done_cyc > res_cyc[2] + 3) begin bad++; $display("FAIL basic_done_time: got done at %0d last result %0d", done_cyc, res_cyc[2]); end
        end
        total++; if (bus.found !== 1'b0) begin bad++; $display("FAIL basic_found: got %0b want 0", bus.found); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %0b want 0", bus.busy); end
        total++; if (m_err != 0) begin bad++; $display("FAIL basic_block: got %0d bad blocks want 0", m_err); end
        total++; if (stable_err != 0) begin bad++; $display("FAIL basic_stable: got %0d changes want 0", stable_err); end
    endtask

    task automatic test_hit();
        for (int it = 0; it < 7; it++) begin
            logic [31:0] first, last, exp_fn;
            int exp_n, c, nerr, serr;
            bit exp_f, ok;
            if (it == 0) begin
                first = 32'd0; last = 32'd99; hit_a = 32'd3; hit_b = 32'd4; lat = 70;
            end else begin
                first = $urandom_range(0, 1000);
                last = first + $urandom_range(0, 20);
                hit_a = ($urandom_range(0, 2) == 0) ? 32'hFFFF_0000 : first + $urandom_range(0, last - first + 2);
                hit_b = hit_a + 32'd1;
                lat = $urandom_range(1, 6) * DELAY + $urandom_range(1, DELAY - 1);
            end
            budget = '1;
            // Issue k happens at k*DELAY unless the first hit's result arrived before then.
            exp_n = 0; exp_f = 1'b0; exp_fn = '0; c = 1 << 30;
            for (int k = 0; k < 200; k++) begin
                logic [31:0] n;
                n = first + k;
                if (DELAY * k >= c) break;
                exp_n++;
                if (!exp_f && (n == hit_a || n == hit_b)) begin
                    exp_f = 1'b1; exp_fn = n; c = DELAY * k + int'(lat);
                end
                if (n >= last) break;
            end
            launch(first, last, rand_target());
            wait_done((exp_n + 2) * DELAY + int'(lat) + 50, ok);
            nerr = 0; serr = 0;
            for (int i = 0; i < issue_nonce.size(); i++) begin
                if (issue_nonce[i] !== first + i) nerr++;
                if (i > 0 && issue_cyc[i] - issue_cyc[i-1] != DELAY) serr++;
            end
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL hit%0d_done: got %0b want 1", it, ok); end
            total++; if (issue_cyc.size() != exp_n) begin bad++; $display("FAIL hit%0d_issues: got %0d want %0d", it, issue_cyc.size(), exp_n); end
            total++; if (nerr != 0) begin bad++; $display("FAIL hit%0d_nonces: got %0d wrong want 0", it, nerr); end
            total++; if (serr != 0) begin bad++; $display("FAIL hit%0d_spacing: got %0d wrong want 0", it, serr); end
            total++; if (res_cyc.size() != exp_n) begin bad++; $display("FAIL hit%0d_results: got %0d want %0d", it, res_cyc.size(), exp_n); end
            total++; if (bus.found !== exp_f) begin bad++; $display("FAIL hit%0d_found: got %0b want %0b", it, bus.found, exp_f); end
            if (exp_f) begin
                total++;
                if (bus.found_nonce !== exp_fn) begin bad++; $display("FAIL hit%0d_found_nonce: got %0d want %0d", it, bus.found_nonce, exp_fn); end
            end
            total++; if (m_err != 0 || stable_err != 0) begin bad++; $display("FAIL hit%0d_block: got %0d/%0d errors want 0", it, m_err, stable_err); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        lat = 1;
        budget = 0;
        hit_a = 32'hFFFF_0000;
        hit_b = 32'hFFFF_0000;
        launch(32'd0, 32'd49, rand_target());
        repeat (DELAY * 12) @(negedge clk);
        total++; if (issue_cyc.size() != DEPTH) begin bad++; $display("FAIL stall_issues: got %0d want %0d", issue_cyc.size(), DEPTH); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %0b want 1", bus.busy); end
        budget = 1;
        repeat (40) @(negedge clk);
        total++; if (issue_cyc.size() != DEPTH + 1) begin bad++; $display("FAIL stall_release: got %0d want %0d", issue_cyc.size(), DEPTH + 1); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        budget = '1;
        wait_done(300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_done: got %0b want 1", ok); end
        total++; if (issue_cyc.size() != DEPTH + 1) begin bad++; $display("FAIL stall_final_issues: got %0d want %0d", issue_cyc.size(), DEPTH + 1); end
        total++; if (res_cyc.size() != DEPTH + 1) begin bad++; $display("FAIL stall_results: got %0d want %0d", res_cyc.size(), DEPTH + 1); end
    endtask

    task automatic test_abort();
        bit ok;
        lat = 80;
        budget = '1;
        hit_a = 32'hFFFF_0000;
        hit_b = 32'hFFFF_0000;
        launch(32'd0, 32'd99, rand_target());
        wait_issues(2, 100);
        repeat (2) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done(400, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abort_done: got %0b want 1", ok); end
        total++; if (issue_cyc.size() != 2) begin bad++; $display("FAIL abort_issues: got %0d want 2", issue_cyc.size()); end
        total++; if (res_cyc.size() != 2) begin bad++; $display("FAIL abort_results: got %0d want 2", res_cyc.size()); end
        total++; if (bus.found !== 1'b0) begin bad++; $display("FAIL abort_found: got %0b want 0", bus.found); end
    endtask

    task automatic test_wrap();
        bit ok;
        lat = 30;
        budget = '1;
        hit_a = 32'h0000_1000;
        hit_b = 32'h0000_1000;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        launch(32'hFFFF_FFFE, 32'hFFFF_FFFF, rand_target());
        wait_done(300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_done: got %0b want 1", ok); end
        total++; if (issue_cyc.size() != 2) begin bad++; $display("FAIL wrap_issues: got %0d want 2", issue_cyc.size()); end
        if (issue_nonce.size() == 2) begin
            total++; if (issue_nonce[0] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_nonce0: got %0h want fffffffe", issue_nonce[0]); end
            total++; if (issue_nonce[1] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_nonce1: got %0h want ffffffff", issue_nonce[1]); end
        end
        launch(32'd10, 32'd3, rand_target());
        wait_done(300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL inverted_done: got %0b want 1", ok); end
        total++; if (issue_cyc.size() != 1) begin bad++; $display("FAIL inverted_issues: got %0d want 1", issue_cyc.size()); end
        if (issue_nonce.size() == 1) begin
            total++; if (issue_nonce[0] !== 32'd10) begin bad++; $display("FAIL inverted_nonce: got %0d want 10", issue_nonce[0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        lat = 80;
        budget = '1;
        hit_a = 32'd0;
        hit_b = 32'hFFFF_0000;
        launch(32'd0, 32'd99, 256'd0);
        wait_issues(3, 100);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bus.en !== 1'b0) begin bad++; $display("FAIL midreset_en: got %0b want 0", bus.en); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %0b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %0b want 0", bus.done); end
        total++; if (bus.M !== 512'd0) begin bad++; $display("FAIL midreset_M: got nonzero want 0"); end
        total++; if (bus.Hin !== 256'd0) begin bad++; $display("FAIL midreset_Hin: got nonzero want 0"); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        total++; if (bus.found !== 1'b0) begin bad++; $display("FAIL stray_found: got %0b want 0", bus.found); end
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL stray_state: got busy=%0b done=%0b want 0/0", bus.busy, bus.done); end
        hit_a = 32'hFFFF_0000;
        lat = 40;
        launch(32'd5, 32'd7, rand_target());
        wait_done(300, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL restart_done: got %0b want 1", ok); end
        total++; if (issue_cyc.size() != 3) begin bad++; $display("FAIL restart_issues: got %0d want 3", issue_cyc.size()); end
        total++; if (res_cyc.size() != 3) begin bad++; $display("FAIL restart_results: got %0d want 3", res_cyc.size()); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        lat = 80;
        budget = '1;
        done_seen = 1'b0;
        m_err = 0;
        stable_err = 0;
        cur_tail = '0;
        cur_mid = '0;
        cur_target = '0;
        hit_a = 32'hFFFF_0000;
        hit_b = 32'hFFFF_0000;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.midstate = '0;
        bus.tail = '0;
        bus.nonce_first = '0;
        bus.nonce_last = '0;
        bus.target = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        test_reset();
        test_basic();
        test_hit();
        test_stall();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nonce_sched.md
NONCE_SCHED -- requirements
Module: nonce_sched

Interface
REQ-001 The module SHALL have parameter DELAY, default 16: minimum cycles between consecutive issue pulses, matching the message-schedule stage.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 8 (power of 2): maximum issued-but-unreturned nonces.
REQ-003 Port clk, input, 1: sole clock, rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle job launch, honoured only in IDLE or DONE.
REQ-006 Port abort, input, 1: stop issuing and drain.
REQ-007 Port midstate, input, 256: chaining value for the job, captured at start.
REQ-008 Port tail, input, 96: last three header words, captured at start.
REQ-009 Port nonce_first and nonce_last, input, 32 each: inclusive nonce range, captured at start.
REQ-010 Port target, input, 256: unsigned threshold, captured at start.
REQ-011 Port en, output, 1: issue pulse to the datapath.
REQ-012 Port M, output, 512: message block accompanying en.
REQ-013 Port Hin, output, 256: chaining value accompanying en.
REQ-014 Port hash_valid, input, 1: one result per issued block, returned in issue order.
REQ-015 Port hash, input, 256: digest qualified by hash_valid.
REQ-016 Port busy, output, 1: high in ISSUE, GAP and DRAIN.
REQ-017 Port done, output, 1: high in DONE.
REQ-018 Port found, output, 1: valid with done; digest <= target was seen.
REQ-019 Port found_nonce, output, 32: nonce of the first qualifying digest.

Function
REQ-020 States SHALL be IDLE, ISSUE, GAP, DRAIN and DONE.
REQ-021 IDLE/DONE + start: capture job inputs, clear found, load nonce counter with nonce_first, go to ISSUE.
REQ-022 ISSUE: en=1 for exactly one cycle, push the current nonce into the tag FIFO, then go to GAP.
REQ-023 M SHALL be, MSB word first: tail[95:64], tail[63:32], tail[31:0], nonce, 32'h80000000, ten zero words, 32'h00000280.
REQ-024 Hin SHALL equal the captured midstate; M and Hin SHALL be held stable outside issue cycles.
REQ-025 GAP: wait DELAY-1 cycles, so en pulses are exactly DELAY cycles apart.
REQ-026 End of GAP: if nonce == nonce_last, or found or abort latched, go to DRAIN.
REQ-027 End of GAP, otherwise: increment nonce (32-bit; no wrap since range is inclusive), then go to ISSUE if the FIFO is not full, else stall in GAP.
REQ-028 hash_valid SHALL pop one FIFO entry in any state.
REQ-029 On the first hash <= target (unsigned, equality qualifies), set found and store the popped nonce in found_nonce; later hits are ignored.
REQ-030 Once found is set, no further issue SHALL occur.
REQ-031 DRAIN: wait until FIFO empty, then go to DONE.
REQ-032 abort SHALL be latched in any busy state and take effect at the next GAP end; abort in IDLE/DONE is ignored.
REQ-033 hash_valid on the same cycle as an issue: push and pop both occur, and occupancy is unchanged.
REQ-034 hash_valid with an empty FIFO SHALL be ignored and SHALL set no state.
REQ-035 nonce_first > nonce_last: exactly one issue (nonce_first), then DRAIN.
REQ-036 start while busy SHALL be ignored.

Reset
REQ-037 On reset low, asynchronously: state=IDLE; en, busy, done, found=0; found_nonce=0; M, Hin=0; FIFO emptied; latched abort cleared.
REQ-038 Reset mid-job discards all in-flight tags; results arriving after reset release are ignored per REQ-034.

Verification
REQ-039 Range 5..7, DELAY=16, results 80 cycles after each issue, none hitting -> en at t0, t0+16, t0+32; nonces 5,6,7; done after third result; found=0.
REQ-040 Range 0..99, digest for nonce 3 equals target exactly -> found=1, found_nonce=3; no issue after the hit cycle; done after all outstanding results return.
REQ-041 Results withheld, FIFO_DEPTH=8 -> exactly 8 issues then stall; the first result releases exactly one further issue.
REQ-042 abort asserted 2 cycles after the second issue -> no third issue; done after 2 results; found=0.
REQ-043 Range 32'hFFFFFFFE..32'hFFFFFFFF -> two issues, no wrap to 0, done.
REQ-044 reset asserted in GAP with 3 tags outstanding -> all outputs 0 immediately; stray hash_valid ignored; new start runs normally.
